// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter (optional leading-zero blanking via BCD_BLANK_LEADING_ZERO_EN)
module bin_to_bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BCD_BLANK_LEADING_ZERO_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX = BIN_W'(10**DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t                state;
  logic [BIN_W-1:0]      shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adj;
  logic [CW-1:0]         cnt;
  logic                  ovf_flag;
  // add 3 to every scratch digit of 5 or more before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = (scratch[4*i+:4] >= 4'd5) ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0] lead;
  logic              z;
  // digit i blanks when it and every more-significant digit are zero; digit 0 never blanks
  always_comb begin
    lead = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z & (scratch[4*i+:4] == 4'h0);
      lead[i] = z;
    end
  end
`endif
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
      blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shreg    <= bin_in;
          scratch  <= '0;
          cnt      <= '0;
          ovf_flag <= bin_in > MAX;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          scratch <= {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) state <= LATCH;
        end
        LATCH: begin
          bcd_out  <= ovf_flag ? {DIGITS{4'h9}} : scratch;
          overflow <= ovf_flag;
`ifdef BCD_BLANK_LEADING_ZERO_EN
          blank    <= ovf_flag ? '0 : lead;
`endif
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: table-driven scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] bin_in = '0;
  logic        busy, done, overflow;
  logic [23:0] bcd_out;
`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [5:0]  blank;
`endif
  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blk;
  } vec_t;
  vec_t vecs[9];
  vec_t exp_q[$];
  vec_t e;
  int   tests = 0;
  int   fails = 0;
  bit   seen;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BCD_BLANK_LEADING_ZERO_EN
    , .blank(blank)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard: every done pulse must match the oldest accepted conversion
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("bcd_out", bcd_out, e.bcd);
        check("overflow", overflow, e.ovf);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        check("blank", blank, e.blk);
`endif
      end
    end
  end
  // called just after the accepting edge; returns at the negedge of the done cycle
  task automatic wait_done(input string name);
    int n = 0;
    bit busy_ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      if (busy !== (n <= 20)) busy_ok = 1'b0;
      if (done) break;
      @(posedge clk);
      n++;
    end
    check({"latency_", name}, n, 21);
    check({"busy_profile_", name}, busy_ok, 1);
  endtask
  task automatic convert(input vec_t v);
    start = 1'b1;
    bin_in = v.bin;
    exp_q.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = 20'($urandom);
    wait_done("vec");
  endtask
  initial begin
    vecs[0] = '{20'd123456,  24'h123456, 1'b0, 6'b000000};
    vecs[1] = '{20'd0,       24'h000000, 1'b0, 6'b111110};
    vecs[2] = '{20'd999999,  24'h999999, 1'b0, 6'b000000};
    vecs[3] = '{20'd5,       24'h000005, 1'b0, 6'b111110};
    vecs[4] = '{20'd1000000, 24'h999999, 1'b1, 6'b000000};
    vecs[5] = '{20'hFFFFF,   24'h999999, 1'b1, 6'b000000};
    vecs[6] = '{20'd10,      24'h000010, 1'b0, 6'b111100};
    vecs[7] = '{20'd100000,  24'h100000, 1'b0, 6'b000000};
    vecs[8] = '{20'd98765,   24'h098765, 1'b0, 6'b100000};
    rst_n = 1'b0;
    start = 1'b1;
    bin_in = 20'd123456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ovf", overflow, 0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    check("rst_blank", blank, 6'b111110);
`endif
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) convert(vecs[i]);
    start = 1'b1;
    bin_in = 20'd42;
    exp_q.push_back('{20'd42, 24'h000042, 1'b0, 6'b111100});
    @(posedge clk);
    #1 bin_in = 20'd777;
    wait_done("hold");
    exp_q.push_back('{20'd777, 24'h000777, 1'b0, 6'b111000});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b");
    start = 1'b1;
    bin_in = 20'd654321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd_out, 0);
    check("midrst_ovf", overflow, 0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    check("midrst_blank", blank, 6'b111110);
`endif
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("no_activity_after_reset", seen, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
